// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-register RV64 shift execution unit.
// All shift forms (SLL/SRL/SRA and the 32-bit W variants) share one
// logical-right barrel shifter (srl).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  synchronous pipeline kill
//   inValid/inReady        upstream handshake for op, amt, dataIn, tagIn
//   outValid/outReady      downstream handshake for dataOut, tagOut, illegal

// srl: N-wide logical-right barrel shifter, one mux level per amount bit.
module srl #(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0]         din,
    input  logic [$clog2(N)-1:0] amt,
    output logic [N-1:0]         dout
);
    localparam int unsigned AW = $clog2(N);

    always_comb begin
        dout = din;
        for (int i = 0; i < AW; i++) begin
            if (amt[i]) dout = dout >> (32'd1 << i);
        end
    end
endmodule

module shift_exec_stage #(
    parameter int unsigned N    = 64,
    parameter int unsigned TAGW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [2:0]           op,
    input  logic [$clog2(N)-1:0] amt,
    input  logic [N-1:0]         dataIn,
    input  logic [TAGW-1:0]      tagIn,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [N-1:0]         dataOut,
    output logic [TAGW-1:0]      tagOut,
    output logic                 illegal
);
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned HW = N - 32;

    // op[1:0] selects the shift kind, op[2] selects the 32-bit W form
    localparam logic [1:0] KIND_SLL = 2'b00;
    localparam logic [1:0] KIND_SRA = 2'b10;
    localparam logic [1:0] KIND_ILL = 2'b11;

    // S1 operand register
    logic            s1_valid_q, s1_valid_d;
    logic [2:0]      s1_op_q,    s1_op_d;
    logic [AW-1:0]   s1_amt_q,   s1_amt_d;
    logic [N-1:0]    s1_data_q,  s1_data_d;
    logic [TAGW-1:0] s1_tag_q,   s1_tag_d;

    // S2 output register
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_data_q,  out_data_d;
    logic [TAGW-1:0] out_tag_q,   out_tag_d;
    logic            out_ill_q,   out_ill_d;

    logic            advance;
    logic            is_w;
    logic [1:0]      kind;
    logic [AW-1:0]   eff_amt;
    logic [N-1:0]    operand;
    logic [N-1:0]    sh_in;
    logic [N-1:0]    sh_out;
    logic [N-1:0]    logical;
    logic [N-1:0]    fill;
    logic [N-1:0]    full;
    logic [N-1:0]    result;
    logic            res_ill;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] x);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = x[N-1-i];
        return r;
    endfunction

    // S1 compute: left shifts are right shifts of the bit-reversed operand
    always_comb begin
        is_w    = s1_op_q[2];
        kind    = s1_op_q[1:0];
        res_ill = (kind == KIND_ILL);
        eff_amt = is_w ? AW'(s1_amt_q[4:0]) : s1_amt_q;
        if (is_w) begin
            if (kind == KIND_SRA) operand = {{HW{s1_data_q[31]}}, s1_data_q[31:0]};
            else                  operand = {{HW{1'b0}}, s1_data_q[31:0]};
        end else begin
            operand = s1_data_q;
        end
        sh_in   = (kind == KIND_SLL) ? bitrev(operand) : operand;
        logical = (kind == KIND_SLL) ? bitrev(sh_out) : sh_out;
        fill    = (kind == KIND_SRA && operand[N-1]) ? ~({N{1'b1}} >> eff_amt) : '0;
        full    = logical | fill;
        if (res_ill)   result = '0;
        else if (is_w) result = {{HW{full[31]}}, full[31:0]};
        else           result = full;
    end

    srl #(.N(N)) u_srl (
        .din  (sh_in),
        .amt  (eff_amt),
        .dout (sh_out)
    );

    // Handshake and next-state; inReady combinationally follows outReady
    always_comb begin
        advance     = !out_valid_q || outReady;
        inReady     = !flush && (!s1_valid_q || advance);

        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_amt_d    = s1_amt_q;
        s1_data_d   = s1_data_q;
        s1_tag_d    = s1_tag_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_ill_d   = out_ill_q;

        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (inReady) begin
            s1_valid_d = inValid;
            if (inValid) begin
                s1_op_d   = op;
                s1_amt_d  = amt;
                s1_data_d = dataIn;
                s1_tag_d  = tagIn;
            end
        end

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = result;
                out_tag_d  = s1_tag_q;
                out_ill_d  = res_ill;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_amt_q    <= '0;
            s1_data_q   <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_ill_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_amt_q    <= s1_amt_d;
            s1_data_q   <= s1_data_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_ill_q   <= out_ill_d;
        end
    end

    assign outValid = out_valid_q;
    assign dataOut  = out_data_q;
    assign tagOut   = out_tag_q;
    assign illegal  = out_ill_q;
endmodule

// File: tb/tb_shift_exec_stage.sv
// tb_shift_exec_stage: directed spot checks plus a randomized stream scored
// against an arithmetic shift model and an in-order expectation queue.
module tb_shift_exec_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [2:0]  op;
    logic [5:0]  amt;
    logic [63:0] dataIn;
    logic [4:0]  tagIn;
    logic        outValid;
    logic        outReady;
    logic [63:0] dataOut;
    logic [4:0]  tagOut;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  got_tags[$];
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [4:0]  prev_tag;
    logic        prev_ill;

    shift_exec_stage #(.N(64), .TAGW(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .inValid  (inValid),
        .inReady  (inReady),
        .op       (op),
        .amt      (amt),
        .dataIn   (dataIn),
        .tagIn    (tagIn),
        .outValid (outValid),
        .outReady (outReady),
        .dataOut  (dataOut),
        .tagOut   (tagOut),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V shift semantics in plain arithmetic
    function automatic exp_t model(input logic [2:0] o, input logic [5:0] a,
                                   input logic [63:0] x, input logic [4:0] t);
        exp_t        e;
        logic [31:0] w;
        e.tag = t;
        e.ill = 1'b0;
        w     = '0;
        case (o)
            3'd0:    e.data = x << a;
            3'd1:    e.data = x >> a;
            3'd2:    e.data = 64'($signed(x) >>> a);
            3'd4:    w = x[31:0] << a[4:0];
            3'd5:    w = x[31:0] >> a[4:0];
            3'd6:    w = 32'($signed(x[31:0]) >>> a[4:0]);
            default: begin e.data = '0; e.ill = 1'b1; end
        endcase
        if (o[2] && o[1:0] != 2'b11) e.data = {{32{w[31]}}, w};
        return e;
    endfunction

    // Scoreboard: sample handshakes mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_data", dataOut, prev_data);
                check("stall_tag", 64'(tagOut), 64'(prev_tag));
                check("stall_ill", 64'(illegal), 64'(prev_ill));
            end
            if (outValid && outReady) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("data", dataOut, e.data);
                    check("tag", 64'(tagOut), 64'(e.tag));
                    check("illegal", 64'(illegal), 64'(e.ill));
                end
                got_tags.push_back(tagOut);
            end
            if (flush) begin
                check("flush_inready", 64'(inReady), 64'(0));
                exp_q.delete();
            end else if (inValid && inReady) begin
                exp_q.push_back(model(op, amt, dataIn, tagIn));
            end
            prev_stall = outValid && !outReady && !flush;
            prev_data  = dataOut;
            prev_tag   = tagOut;
            prev_ill   = illegal;
        end
    end

    task automatic drain();
        @(posedge clk); #1;
        inValid  = 1'b0;
        flush    = 1'b0;
        outReady = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // Single op into an empty pipeline; checks the 2-edge latency and result
    task automatic send_check(input string name, input logic [2:0] o, input logic [5:0] a,
                              input logic [63:0] d, input logic [4:0] t,
                              input logic [63:0] e, input logic e_ill);
        @(posedge clk); #1;
        inValid  = 1'b1;
        op       = o;
        amt      = a;
        dataIn   = d;
        tagIn    = t;
        outReady = 1'b1;
        @(negedge clk);
        check({name, "_inready"}, 64'(inReady), 64'(1));
        @(posedge clk); #1;
        inValid = 1'b0;
        check({name, "_lat1"}, 64'(outValid), 64'(0));
        @(posedge clk); #1;
        check({name, "_lat2"}, 64'(outValid), 64'(1));
        check({name, "_data"}, dataOut, e);
        check({name, "_tag"}, 64'(tagOut), 64'(t));
        check({name, "_ill"}, 64'(illegal), 64'(e_ill));
    endtask

    initial begin
        int   idx;
        int   stall_left;
        logic saw_block;

        rst_n    = 1'b0;
        flush    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        op       = '0;
        amt      = '0;
        dataIn   = '0;
        tagIn    = '0;
        #1;
        check("rst_outvalid", 64'(outValid), 64'(0));
        check("rst_data", dataOut, 64'(0));
        check("rst_tag", 64'(tagOut), 64'(0));
        check("rst_ill", 64'(illegal), 64'(0));
        #20;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_inready", 64'(inReady), 64'(1));

        send_check("srl63", 3'd1, 6'd63, 64'h8000_0000_0000_0001, 5'd1, 64'h1, 1'b0);
        send_check("srl0", 3'd1, 6'd0, 64'hDEAD_BEEF_0123_4567, 5'd2, 64'hDEAD_BEEF_0123_4567, 1'b0);
        send_check("sra4", 3'd2, 6'd4, 64'h8000_0000_0000_0000, 5'd3, 64'hF800_0000_0000_0000, 1'b0);
        send_check("sll63", 3'd0, 6'd63, 64'h1, 5'd4, 64'h8000_0000_0000_0000, 1'b0);
        send_check("sllw33", 3'd4, 6'd33, 64'h0000_0000_4000_0001, 5'd5, 64'hFFFF_FFFF_8000_0002, 1'b0);
        send_check("sraw31", 3'd6, 6'd31, 64'h1234_5678_8000_0000, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_check("srlw31", 3'd5, 6'd31, 64'h1234_5678_8000_0000, 5'd7, 64'h1, 1'b0);
        send_check("srlw0", 3'd5, 6'd0, 64'h0000_0000_8000_0000, 5'd8, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send_check("illegal", 3'b011, 6'd5, 64'hFFFF_0000_FFFF_0000, 5'd9, 64'h0, 1'b1);
        drain();

        // Backpressure: four SRL ops, outReady held low 4 cycles after the first result
        got_tags.delete();
        idx        = 0;
        stall_left = -1;
        saw_block  = 1'b0;
        for (int c = 0; c < 40 && got_tags.size() < 4; c++) begin
            @(posedge clk); #1;
            inValid = (idx < 4);
            op      = 3'd1;
            amt     = 6'($urandom);
            dataIn  = {$urandom, $urandom};
            tagIn   = 5'(idx + 1);
            if (outValid && stall_left < 0) stall_left = 4;
            if (stall_left > 0) begin
                outReady = 1'b0;
                stall_left--;
            end else begin
                outReady = 1'b1;
            end
            @(negedge clk);
            if (!inReady && outValid && !outReady) saw_block = 1'b1;
            if (inValid && inReady) idx++;
        end
        check("bp_inready_dropped", 64'(saw_block), 64'(1));
        drain();
        check("bp_count", 64'(got_tags.size()), 64'(4));
        for (int i = 0; i < 4 && i < got_tags.size(); i++)
            check("bp_order", 64'(got_tags[i]), 64'(i + 1));

        // Flush with both stages full and a new op presented
        outReady = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            inValid = 1'b1;
            op      = 3'd2;
            amt     = 6'($urandom);
            dataIn  = {$urandom, $urandom};
            tagIn   = 5'(c + 10);
            @(negedge clk);
            if (!inReady) break;
        end
        check("flush_full", 64'(outValid && !inReady), 64'(1));
        @(posedge clk); #1;
        inValid = 1'b1;
        tagIn   = 5'h1F;
        flush   = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        check("flush_outvalid", 64'(outValid), 64'(0));
        repeat (3) begin
            @(posedge clk); #1;
            check("flush_empty", 64'(outValid), 64'(0));
        end

        // Randomized stream with backpressure and occasional flush
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            inValid  = 1'($urandom_range(0, 1));
            op       = 3'($urandom_range(0, 7));
            amt      = 6'($urandom);
            dataIn   = {$urandom, $urandom};
            tagIn    = 5'($urandom);
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 40) == 0);
        end
        drain();
        check("stream_drained", 64'(exp_q.size()), 64'(0));

        // Reset mid-stream, between edges
        outReady = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            inValid = 1'b1;
            op      = 3'd0;
            amt     = 6'($urandom);
            dataIn  = {$urandom, $urandom} | 64'h1;
            tagIn   = 5'($urandom) | 5'h1;
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_outvalid", 64'(outValid), 64'(0));
        check("midrst_data", dataOut, 64'(0));
        check("midrst_tag", 64'(tagOut), 64'(0));
        check("midrst_ill", 64'(illegal), 64'(0));
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("postrst_inready", 64'(inReady), 64'(1));
        send_check("postrst", 3'd1, 6'd4, 64'h0000_0000_0000_00F0, 5'd9, 64'hF, 1'b0);
        drain();
        check("final_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/shift_exec_stage.md
# shift_exec_stage

Pipelined RV64 shift execution unit in the NeanderRV64 integer datapath. It sits between issue and writeback and drives the team's `srl` logical-right barrel shifter. SLL, SRL and SRA, plus their 32-bit W forms, are all mapped onto that single right shifter. Operands and results move over valid/ready handshakes through two register stages, so it sustains one op per cycle under backpressure.

## Interface
- `N`, 64: datapath width (XLEN); must be a power of two ≥ 64.
- `TAGW`, 5: width of the destination-register tag carried alongside each op.
- `clk`  in  1  clock, all state rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous pipeline kill.
- `inValid`  in  1  upstream offers an op.
- `inReady`  out  1  stage accepts the op this cycle.
- `op`  in  3  shift operation code: 000 SLL, 001 SRL, 010 SRA, 100 SLLW, 101 SRLW, 110 SRAW; all others illegal.
- `amt`  in  $clog2(N)  shift amount.
- `dataIn`  in  N  operand.
- `tagIn`  in  TAGW  destination tag.
- `outValid`  out  1  result available.
- `outReady`  in  1  downstream consumes the result.
- `dataOut`  out  N  result.
- `tagOut`  out  TAGW  tag of the result.
- `illegal`  out  1  result came from an illegal op code; qualified by `outValid`.

## Operation
- **S1 (operand register).** Holds `s1Valid`, `op`, `amt`, `dataIn` and `tagIn`. It loads on accept, where accept = `inValid && inReady`.
- **S1 compute (combinational).** Every op goes through one N-wide `srl` instance.
  - SRL: the shifter input is the operand.
  - SLL: bit-reverse the operand, shift right, then bit-reverse the result.
  - SRA: logical result OR a fill mask. The mask is `~(all-ones >> amt)` when operand bit N-1 is 1, otherwise 0.
  - W ops: the effective amount is `amt[4:0]` and `amt[5]` is ignored.
    - Operand for SRLW/SLLW: `{32'b0, dataIn[31:0]}`.
    - Operand for SRAW: `{{32{dataIn[31]}}, dataIn[31:0]}`.
    - The final result is bits [31:0] sign-extended from bit 31.
  - 64-bit ops use all 6 bits of `amt`. A shift of 0 returns the operand unchanged, sign-extended for W ops.
  - Illegal op: the result is 0 and `illegal` = 1.
- **S2 (output register).** Holds `outValid`, `dataOut`, `tagOut` and `illegal`. It loads from S1 when S1 advances.
- **Advance rules.**
  - S1 advances when `!outValid || outReady`.
  - `inReady = !flush && (!s1Valid || advance)`. This is a combinational path from `outReady`, and it is intentional.
- **No loss, no reorder.** Ops leave in acceptance order. No op is dropped or duplicated while `flush` is low.
- **Flush.**
  - On the edge where `flush` = 1, `s1Valid` and `outValid` clear. Any input presented that cycle is not accepted (`inReady` = 0).
  - A result handshaking on that same edge (`outValid && outReady`) counts as consumed.
- **Reset (asynchronous, `rst_n` low).** `s1Valid` = 0, `outValid` = 0, `dataOut` = 0, `tagOut` = 0, `illegal` = 0.
  - All S1 data registers are also 0.
  - `inReady` = 1 while out of reset with empty stages, and stays 0 while `flush` is high.
- **Reset mid-operation.** Reset discards in-flight ops with no output handshake. The first accept after release starts a clean pipeline.

## Timing
- **Latency.** An op accepted on edge k appears with `outValid` = 1 after edge k+1, provided S2 was free. Minimum latency is 2 edges, input to registered output.
- **Throughput.** One op per cycle while `outReady` = 1.
- **Backpressure.**
  - With `outReady` held low and both stages full, `inReady` drops to 0 in the same cycle.
  - In the cycle `outReady` rises, S2 drains, S1 moves to S2, and a new op is accepted, all on the same edge.
- **Output stability.** `dataOut`, `tagOut` and `illegal` hold steady while `outValid && !outReady`.
- **Upstream obligation.** Inputs only need to be stable while `inValid` is high; nothing is sampled otherwise.

## Test plan
- **SRL.** SRL, `dataIn` = 0x8000_0000_0000_0001, `amt` = 63 -> `dataOut` = 0x0000_0000_0000_0001 on the second edge after accept. With `amt` = 0 -> the operand returns unchanged.
- **SRA/SLL.** SRA, `dataIn` = 0x8000_0000_0000_0000, `amt` = 4 -> 0xF800_0000_0000_0000. SLL, `dataIn` = 0x1, `amt` = 63 -> 0x8000_0000_0000_0000.
- **W forms.**
  - SLLW, `dataIn` = 0x0000_0000_4000_0001, `amt` = 33 (effective 1) -> 0xFFFF_FFFF_8000_0002.
  - SRAW, `dataIn` = 0x1234_5678_8000_0000, `amt` = 31 -> 0xFFFF_FFFF_FFFF_FFFF.
  - SRLW, same operand and `amt` -> 0x0000_0000_0000_0001.
- **Backpressure.** Stream 4 SRL ops with tags 1..4, holding `outReady` low for 4 cycles after the first result -> `inReady` falls with both stages full. Results then emerge in tag order 1,2,3,4, none lost or duplicated, with outputs stable while stalled.
- **Illegal op and flush.**
  - `op` = 011 -> `dataOut` = 0, `illegal` = 1, tag preserved.
  - Assert `flush` with both stages full and `inValid` = 1 -> the next cycle has `outValid` = 0, and the flushed-cycle input never appears.
- **Reset mid-stream.** Pull `rst_n` low mid-stream, between clock edges -> outputs immediately 0, `outValid` = 0. After release, a fresh op completes with 2-edge latency.
